// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: deserialises a strobed time field and 2-channel sample stream into words.
// Ports: clk/reset (sync, active-high); sending_data frame envelope; SL_time/SL_ch start strobes;
//        serial_in[0] time/ch1 bits, serial_in[1] ch2 bits; time_word/time_valid, sample_ch1/ch2/
//        sample_valid, sample_count, frame_done pulse, sticky protocol_error.
module serial_frame_receiver #(
    parameter int TIME_W = 32,
    parameter int CH_W   = 3,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sending_data,
    input  logic              SL_time,
    input  logic              SL_ch,
    input  logic [1:0]        serial_in,
    output logic [TIME_W-1:0] time_word,
    output logic              time_valid,
    output logic [CH_W-1:0]   sample_ch1,
    output logic [CH_W-1:0]   sample_ch2,
    output logic              sample_valid,
    output logic [CNT_W-1:0]  sample_count,
    output logic              frame_done,
    output logic              protocol_error
);
    localparam int BW = $clog2(TIME_W > CH_W ? TIME_W : CH_W);
    localparam logic [BW-1:0] T_LAST = BW'(TIME_W - 1);
    localparam logic [BW-1:0] C_LAST = BW'(CH_W - 1);
    localparam logic [1:0] IDLE = 2'd0, TIME_SHIFT = 2'd1, WAIT_SL = 2'd2, CH_SHIFT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [TIME_W-1:0] sr_q, sr_d, sr_sh;
    logic [CH_W-1:0]   sr2_q, sr2_d, sr2_sh;
    logic [TIME_W-1:0] time_word_q, time_word_d;
    logic [CH_W-1:0]   ch1_q, ch1_d, ch2_q, ch2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tv_q, tv_d, sv_q, sv_d, fd_q, fd_d, err_q, err_d;

    // ch1 shares the time shift register: both arrive on serial_in[0] and never overlap.
    assign sr_sh  = {sr_q[TIME_W-2:0], serial_in[0]};
    assign sr2_sh = {sr2_q[CH_W-2:0], serial_in[1]};

    // Shift state defaults to cleared so any (re)entry into a shift state starts fresh
    // and aborted partial words are discarded implicitly.
    always_comb begin
        state_d     = state_q;
        bit_d       = '0;
        sr_d        = '0;
        sr2_d       = '0;
        time_word_d = time_word_q;
        ch1_d       = ch1_q;
        ch2_d       = ch2_q;
        cnt_d       = cnt_q;
        tv_d        = 1'b0;
        sv_d        = 1'b0;
        fd_d        = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (sending_data && SL_time) begin
                    state_d = TIME_SHIFT;
                    cnt_d   = '0;
                    err_d   = SL_ch;
                end else if (SL_ch) begin
                    err_d = 1'b1;
                end
            end
            WAIT_SL: begin
                if (!sending_data) begin
                    fd_d    = 1'b1;
                    state_d = IDLE;
                end else if (SL_time) begin
                    err_d = 1'b1;
                end else if (SL_ch) begin
                    state_d = CH_SHIFT;
                end
            end
            default: begin
                if (!sending_data) begin
                    err_d   = 1'b1;
                    fd_d    = 1'b1;
                    state_d = IDLE;
                end else if (SL_time || SL_ch) begin
                    err_d   = 1'b1;
                    state_d = SL_time ? TIME_SHIFT : CH_SHIFT;
                end else if (state_q == TIME_SHIFT) begin
                    bit_d = bit_q + 1'b1;
                    sr_d  = sr_sh;
                    if (bit_q == T_LAST) begin
                        time_word_d = sr_sh;
                        tv_d        = 1'b1;
                        state_d     = WAIT_SL;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                    sr_d  = sr_sh;
                    sr2_d = sr2_sh;
                    if (bit_q == C_LAST) begin
                        ch1_d   = sr_sh[CH_W-1:0];
                        ch2_d   = sr2_sh;
                        sv_d    = 1'b1;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                        state_d = WAIT_SL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            sr_q        <= '0;
            sr2_q       <= '0;
            time_word_q <= '0;
            ch1_q       <= '0;
            ch2_q       <= '0;
            cnt_q       <= '0;
            tv_q        <= 1'b0;
            sv_q        <= 1'b0;
            fd_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            sr2_q       <= sr2_d;
            time_word_q <= time_word_d;
            ch1_q       <= ch1_d;
            ch2_q       <= ch2_d;
            cnt_q       <= cnt_d;
            tv_q        <= tv_d;
            sv_q        <= sv_d;
            fd_q        <= fd_d;
            err_q       <= err_d;
        end
    end

    assign time_word      = time_word_q;
    assign time_valid     = tv_q;
    assign sample_ch1     = ch1_q;
    assign sample_ch2     = ch2_q;
    assign sample_valid   = sv_q;
    assign sample_count   = cnt_q;
    assign frame_done     = fd_q;
    assign protocol_error = err_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed self-checking bench for serial_frame_receiver.
module tb_serial_frame_receiver;
    logic        clk = 1'b0;
    logic        reset = 1'b0, sending_data = 1'b0, SL_time = 1'b0, SL_ch = 1'b0;
    logic [1:0]  serial_in = 2'b00;
    logic [31:0] time_word;
    logic        time_valid, sample_valid, frame_done, protocol_error;
    logic [2:0]  sample_ch1, sample_ch2;
    logic [8:0]  sample_count;
    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0, s0 = 0, tv_cyc = 0, sv_cyc = 0, tv_n = 0, sv_n = 0, fd_n = 0;

    serial_frame_receiver #(.TIME_W(32), .CH_W(3), .CNT_W(9)) dut (
        .clk(clk), .reset(reset), .sending_data(sending_data), .SL_time(SL_time), .SL_ch(SL_ch),
        .serial_in(serial_in), .time_word(time_word), .time_valid(time_valid),
        .sample_ch1(sample_ch1), .sample_ch2(sample_ch2), .sample_valid(sample_valid),
        .sample_count(sample_count), .frame_done(frame_done), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (time_valid) begin tv_n++; tv_cyc = cyc; end
        if (sample_valid) begin sv_n++; sv_cyc = cyc; end
        if (frame_done) fd_n++;
    endtask

    task automatic clr;
        tv_n = 0; sv_n = 0; fd_n = 0;
    endtask

    task automatic send_time(input logic [31:0] w, input logic both);
        sending_data = 1'b1; SL_time = 1'b1; SL_ch = both; t0 = cyc;
        tick;
        SL_time = 1'b0; SL_ch = 1'b0;
        for (int i = 31; i >= 0; i--) begin serial_in[0] = w[i]; tick; end
        serial_in = 2'b00;
    endtask

    task automatic send_sample(input logic [2:0] a, input logic [2:0] b);
        SL_ch = 1'b1; s0 = cyc;
        tick;
        SL_ch = 1'b0;
        for (int i = 2; i >= 0; i--) begin serial_in = {b[i], a[i]}; tick; end
        serial_in = 2'b00;
    endtask

    task automatic test_reset;
        reset = 1'b1; tick; tick; reset = 1'b0;
        checks++; if (time_word !== 32'h0) begin errors++; $display("FAIL reset_time got %h exp 0", time_word); end
        checks++; if ({sample_ch1, sample_ch2} !== 6'h0) begin errors++; $display("FAIL reset_ch got %h exp 0", {sample_ch1, sample_ch2}); end
        checks++; if (sample_count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", sample_count); end
        checks++; if ({time_valid, sample_valid, frame_done, protocol_error} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {time_valid, sample_valid, frame_done, protocol_error}); end
    endtask

    task automatic test_full_frame;
        clr;
        send_time(32'hA5C3_1F07, 1'b0);
        checks++; if (time_word !== 32'hA5C3_1F07) begin errors++; $display("FAIL ff_time got %h exp a5c31f07", time_word); end
        checks++; if (tv_n !== 1 || tv_cyc - t0 !== 33) begin errors++; $display("FAIL ff_tv_latency got n=%0d cyc=%0d exp n=1 cyc=33", tv_n, tv_cyc - t0); end
        tick;
        send_sample(3'b101, 3'b010);
        checks++; if (sv_cyc - s0 !== 4) begin errors++; $display("FAIL ff_sv_latency got %0d exp 4", sv_cyc - s0); end
        checks++; if (sample_ch1 !== 3'b101 || sample_ch2 !== 3'b010 || sample_count !== 9'd1) begin errors++; $display("FAIL ff_s1 got %b %b %0d exp 101 010 1", sample_ch1, sample_ch2, sample_count); end
        send_sample(3'b111, 3'b000);
        sending_data = 1'b0; tick;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL ff_done got %b exp 1", frame_done); end
        tick;
        checks++; if (sv_n !== 2 || fd_n !== 1 || frame_done !== 1'b0) begin errors++; $display("FAIL ff_pulses got sv=%0d fd=%0d done=%b exp 2 1 0", sv_n, fd_n, frame_done); end
        checks++; if (sample_ch1 !== 3'b111 || sample_ch2 !== 3'b000 || sample_count !== 9'd2) begin errors++; $display("FAIL ff_s2 got %b %b %0d exp 111 000 2", sample_ch1, sample_ch2, sample_count); end
        checks++; if (protocol_error !== 1'b0 || time_word !== 32'hA5C3_1F07) begin errors++; $display("FAIL ff_hold got err=%b time=%h exp 0 a5c31f07", protocol_error, time_word); end
    endtask

    task automatic test_abort_ch;
        send_time(32'h0000_00FF, 1'b0);
        send_sample(3'b011, 3'b100);
        clr;
        SL_ch = 1'b1; tick; SL_ch = 1'b0;
        serial_in = 2'b11; tick;
        sending_data = 1'b0; serial_in = 2'b00; tick;
        checks++; if (frame_done !== 1'b1 || protocol_error !== 1'b1) begin errors++; $display("FAIL abort_flags got done=%b err=%b exp 1 1", frame_done, protocol_error); end
        checks++; if (sv_n !== 0 || sample_count !== 9'd1 || sample_ch1 !== 3'b011 || sample_ch2 !== 3'b100) begin errors++; $display("FAIL abort_hold got sv=%0d cnt=%0d ch=%b %b exp 0 1 011 100", sv_n, sample_count, sample_ch1, sample_ch2); end
        tick;
    endtask

    task automatic test_sl_ch_in_time;
        clr;
        sending_data = 1'b1; SL_time = 1'b1; tick; SL_time = 1'b0;
        checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL slch_clear got %b exp 0", protocol_error); end
        for (int i = 1; i <= 9; i++) begin serial_in[0] = 1'b1; tick; end
        send_sample(3'b110, 3'b001);
        checks++; if (protocol_error !== 1'b1 || tv_n !== 0 || time_word !== 32'h0000_00FF) begin errors++; $display("FAIL slch_err got err=%b tv=%0d time=%h exp 1 0 000000ff", protocol_error, tv_n, time_word); end
        checks++; if (sv_n !== 1 || sample_ch1 !== 3'b110 || sample_ch2 !== 3'b001 || sample_count !== 9'd1) begin errors++; $display("FAIL slch_sample got sv=%0d ch=%b %b cnt=%0d exp 1 110 001 1", sv_n, sample_ch1, sample_ch2, sample_count); end
        sending_data = 1'b0; tick; tick;
    endtask

    task automatic test_saturation;
        send_time(32'h0, 1'b0);
        for (int i = 0; i < 511; i++) send_sample(3'(i), 3'(~i));
        checks++; if (sample_count !== 9'd511) begin errors++; $display("FAIL sat_511 got %0d exp 511", sample_count); end
        clr;
        send_sample(3'b010, 3'b101);
        checks++; if (sv_n !== 1 || sample_count !== 9'd511 || sample_ch1 !== 3'b010 || sample_ch2 !== 3'b101) begin errors++; $display("FAIL sat_512 got sv=%0d cnt=%0d ch=%b %b exp 1 511 010 101", sv_n, sample_count, sample_ch1, sample_ch2); end
        sending_data = 1'b0; tick; tick;
    endtask

    task automatic test_reset_mid;
        send_time(32'hDEAD_BEEF, 1'b0);
        send_sample(3'b001, 3'b001);
        SL_time = 1'b1; tick; SL_time = 1'b0;
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL sltime_wait got %b exp 1", protocol_error); end
        SL_ch = 1'b1; tick; SL_ch = 1'b0;
        serial_in = 2'b11; tick;
        reset = 1'b1; tick; reset = 1'b0; serial_in = 2'b00;
        checks++; if (time_word !== 32'h0 || {sample_ch1, sample_ch2} !== 6'h0 || sample_count !== 9'd0) begin errors++; $display("FAIL rmid_data got %h %b %b %0d exp 0", time_word, sample_ch1, sample_ch2, sample_count); end
        checks++; if ({time_valid, sample_valid, frame_done, protocol_error} !== 4'b0) begin errors++; $display("FAIL rmid_flags got %b exp 0000", {time_valid, sample_valid, frame_done, protocol_error}); end
        clr;
        send_time(32'h1234_5678, 1'b0);
        send_sample(3'b100, 3'b011);
        sending_data = 1'b0; tick;
        checks++; if (time_word !== 32'h1234_5678 || sample_ch1 !== 3'b100 || sample_ch2 !== 3'b011) begin errors++; $display("FAIL rmid_frame got %h %b %b exp 12345678 100 011", time_word, sample_ch1, sample_ch2); end
        checks++; if (sample_count !== 9'd1 || protocol_error !== 1'b0 || fd_n !== 1 || tv_n !== 1) begin errors++; $display("FAIL rmid_stat got cnt=%0d err=%b fd=%0d tv=%0d exp 1 0 1 1", sample_count, protocol_error, fd_n, tv_n); end
        tick;
    endtask

    task automatic test_both_strobes;
        SL_ch = 1'b1; tick; SL_ch = 1'b0;
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL slch_idle got %b exp 1", protocol_error); end
        clr;
        send_time(32'h0F0F_A5A5, 1'b1);
        checks++; if (tv_n !== 1 || time_word !== 32'h0F0F_A5A5 || protocol_error !== 1'b1) begin errors++; $display("FAIL both got tv=%0d time=%h err=%b exp 1 0f0fa5a5 1", tv_n, time_word, protocol_error); end
        sending_data = 1'b0; tick; tick;
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_abort_ch;
        test_sl_ch_in_time;
        test_saturation;
        test_reset_mid;
        test_both_strobes;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
